riscv_core_div_ctrl: RTL
========================

Name: riscv_core_div_ctrl

Overview:
RV64M divide front/back end. It sits between the execute-stage issue logic and the unsigned 64-bit non-restoring divider core. It decodes DIV/DIVU/REM/REMU and their W variants, and resolves divide-by-zero and signed overflow locally without starting the core. Other operations are converted to unsigned magnitudes, issued to the core, and the result is sign-corrected and returned with a valid pulse.

Parameters:
XLEN, 64, datapath width; only 64 is supported (W ops use bits [31:0]).

Ports:
i_div_ctrl_clk  in  1  clock, all state on rising edge
i_div_ctrl_rst  in  1  synchronous, active-high reset
i_div_ctrl_valid  in  1  operation request
o_div_ctrl_ready  out  1  high when an operation can be accepted (state IDLE)
i_div_ctrl_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
i_div_ctrl_word  in  1  1 = W variant (DIVW/DIVUW/REMW/REMUW)
i_div_ctrl_rs1  in  XLEN  dividend
i_div_ctrl_rs2  in  XLEN  divisor
i_div_ctrl_flush  in  1  squash the in-flight operation
o_div_ctrl_valid  out  1  one-cycle result pulse
o_div_ctrl_result  out  XLEN  result; held until the next result
o_div_ctrl_core_en  out  1  start pulse to the divider core
o_div_ctrl_core_dividend  out  XLEN  unsigned dividend magnitude (registered)
o_div_ctrl_core_divisor  out  XLEN  unsigned divisor magnitude (registered, stable through WAIT)
i_div_ctrl_core_done  in  1  core done; quotient and remainder are valid only in this cycle
i_div_ctrl_core_quotient  in  XLEN  unsigned quotient
i_div_ctrl_core_remainder  in  XLEN  unsigned remainder

Behaviour:
- Reset (sync, high): state=IDLE, o_valid=0, o_result=0, core operand registers=0, o_core_en=0. The integration asserts the core reset whenever this reset is asserted.
- Accept: i_valid & o_ready & !i_flush at edge T. Flush has priority; a request presented with flush is dropped.
- Operand prep:
  - signed = !op[0].
  - W ops use a = signed ? sext(rs1[31:0]) : zext(rs1[31:0]); b is formed the same way from rs2.
  - neg_a = signed & a[63]; neg_b = signed & b[63].
  - Magnitudes are |a| and |b| via two's-complement negate when neg. The most-negative value maps to itself, which is correct as an unsigned value.
- Special cases, decided at accept time; these never assert core_en:
  - b==0: quotient = all ones; remainder = a.
  - Signed overflow (a = most negative of the op width, b = -1): quotient = a; remainder = 0.
  - Result is registered at T+1 with o_valid=1 in cycle T+1; state stays IDLE.
- States:
  - IDLE: o_ready=1. A normal accept registers magnitudes, neg flags, op, and word, then moves to ISSUE.
  - ISSUE: o_core_en=1 for exactly this cycle, then WAIT.
  - WAIT: on core_done, select quotient (op[1]=0) or remainder (op[1]=1), then post-process, register o_result, set o_valid next cycle, and return to IDLE.
  - DRAIN: o_ready=0. Waits for core_done, discards the result, and returns to IDLE without o_valid.
- Post-process:
  - The quotient is negated if neg_a^neg_b.
  - The remainder is negated if neg_a.
  - For W ops the final value is sext(value[31:0]), including DIVUW/REMUW.
- Latency: the core runs 64 cycles. Accept at T, core_en at T+1, core_done at T+65, o_valid at T+66.
- Throughput: a new op may be accepted in the o_valid cycle (state is already IDLE).
- Flush:
  - In ISSUE: core_en is still asserted, and the state goes to DRAIN.
  - In WAIT without core_done: go to DRAIN.
  - In WAIT with core_done in the same cycle: the result is discarded and the state goes to IDLE.
  - Flush in the cycle o_valid is high does not retract the result.
- core_done is ignored in IDLE.
- o_valid is high for exactly one cycle per completed, unflushed op.
- Reset mid-operation returns to IDLE immediately, with no o_valid.

Test Plan:
1. DIVU rs1=100, rs2=7 -> core_en at T+1, o_valid at T+66, result=14. REMU with the same operands -> 2.
2. DIV rs1=-20, rs2=3 -> 0xFFFFFFFFFFFFFFFA (-6). REM -> 0xFFFFFFFFFFFFFFFE (-2). REM rs1=20, rs2=-3 -> 2.
3. DIVU rs1=5, rs2=0 -> result 0xFFFFFFFFFFFFFFFF at T+1, core_en never high. REMU -> 5. REMW rs1=0x1_80000000, rs2=0 -> 0xFFFFFFFF80000000.
4. DIV rs1=0x8000000000000000, rs2=-1 -> 0x8000000000000000 at T+1, REM -> 0. DIVW rs1=0x80000000, rs2=0xFFFFFFFF -> 0xFFFFFFFF80000000.
5. DIVW rs1=0x00000001_FFFFFFF8, rs2=2 -> 0xFFFFFFFFFFFFFFFC. DIVUW with the same operands -> 0x000000007FFFFFFC.
6. DIVU 100/7 with flush 10 cycles after accept -> no o_valid, o_ready low until core_done. A DIVU 9/4 issued next -> result 2, exactly one o_valid. A sync reset mid-WAIT -> IDLE next cycle, o_valid=0.

Source files
------------

// File: rtl/riscv_core_div_ctrl_if.sv
// Request/response and divider-core handshake bundle for riscv_core_div_ctrl.
// slave = the divide controller; master = issue logic plus divider core.
interface riscv_core_div_ctrl_if #(
    parameter int unsigned XLEN = 64
);
    logic            i_div_ctrl_valid;
    logic            o_div_ctrl_ready;
    logic [1:0]      i_div_ctrl_op;
    logic            i_div_ctrl_word;
    logic [XLEN-1:0] i_div_ctrl_rs1;
    logic [XLEN-1:0] i_div_ctrl_rs2;
    logic            i_div_ctrl_flush;
    logic            o_div_ctrl_valid;
    logic [XLEN-1:0] o_div_ctrl_result;
    logic            o_div_ctrl_core_en;
    logic [XLEN-1:0] o_div_ctrl_core_dividend;
    logic [XLEN-1:0] o_div_ctrl_core_divisor;
    logic            i_div_ctrl_core_done;
    logic [XLEN-1:0] i_div_ctrl_core_quotient;
    logic [XLEN-1:0] i_div_ctrl_core_remainder;

    modport slave (
        input  i_div_ctrl_valid, i_div_ctrl_op, i_div_ctrl_word,
        input  i_div_ctrl_rs1, i_div_ctrl_rs2, i_div_ctrl_flush,
        input  i_div_ctrl_core_done, i_div_ctrl_core_quotient, i_div_ctrl_core_remainder,
        output o_div_ctrl_ready, o_div_ctrl_valid, o_div_ctrl_result,
        output o_div_ctrl_core_en, o_div_ctrl_core_dividend, o_div_ctrl_core_divisor
    );

    modport master (
        output i_div_ctrl_valid, i_div_ctrl_op, i_div_ctrl_word,
        output i_div_ctrl_rs1, i_div_ctrl_rs2, i_div_ctrl_flush,
        output i_div_ctrl_core_done, i_div_ctrl_core_quotient, i_div_ctrl_core_remainder,
        input  o_div_ctrl_ready, o_div_ctrl_valid, o_div_ctrl_result,
        input  o_div_ctrl_core_en, o_div_ctrl_core_dividend, o_div_ctrl_core_divisor
    );
endinterface

// File: rtl/riscv_core_div_ctrl.sv
// RV64M divide controller: decodes DIV/DIVU/REM/REMU(+W), resolves x/0 and
// signed overflow locally, otherwise drives the unsigned divider core and sign-corrects.
module riscv_core_div_ctrl #(
    parameter int unsigned XLEN = 64
) (
    input  logic                  i_div_ctrl_clk,
    input  logic                  i_div_ctrl_rst,
    riscv_core_div_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    state_t          state;
    logic [1:0]      op_r;
    logic            word_r;
    logic            neg_a_r;
    logic            neg_b_r;
    logic            valid_r;
    logic            core_en_r;
    logic [XLEN-1:0] result_r;
    logic [XLEN-1:0] dividend_r;
    logic [XLEN-1:0] divisor_r;

    logic            is_signed;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] min_neg;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] spec_val;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] core_val;
    logic            neg_res;
    logic [XLEN-1:0] signed_val;
    logic [XLEN-1:0] post_res;
    logic            accept;

    assign bus.o_div_ctrl_ready         = (state == IDLE);
    assign bus.o_div_ctrl_valid         = valid_r;
    assign bus.o_div_ctrl_result        = result_r;
    assign bus.o_div_ctrl_core_en       = core_en_r;
    assign bus.o_div_ctrl_core_dividend = dividend_r;
    assign bus.o_div_ctrl_core_divisor  = divisor_r;

    assign accept = bus.i_div_ctrl_valid & (state == IDLE) & ~bus.i_div_ctrl_flush;

    // Operand preparation and special-case detection for the incoming request.
    always_comb begin
        is_signed = ~bus.i_div_ctrl_op[0];
        if (bus.i_div_ctrl_word) begin
            op_a = {{(XLEN-32){is_signed & bus.i_div_ctrl_rs1[31]}}, bus.i_div_ctrl_rs1[31:0]};
            op_b = {{(XLEN-32){is_signed & bus.i_div_ctrl_rs2[31]}}, bus.i_div_ctrl_rs2[31:0]};
            min_neg = {{(XLEN-31){1'b1}}, 31'b0};
        end else begin
            op_a = bus.i_div_ctrl_rs1;
            op_b = bus.i_div_ctrl_rs2;
            min_neg = {1'b1, {(XLEN-1){1'b0}}};
        end
        neg_a    = is_signed & op_a[XLEN-1];
        neg_b    = is_signed & op_b[XLEN-1];
        mag_a    = neg_a ? -op_a : op_a;
        mag_b    = neg_b ? -op_b : op_b;
        div_zero = (op_b == '0);
        overflow = is_signed & (op_a == min_neg) & (op_b == '1);
        special  = div_zero | overflow;
        if (bus.i_div_ctrl_op[1]) begin
            spec_val = div_zero ? op_a : '0;
        end else begin
            spec_val = div_zero ? '1 : op_a;
        end
        spec_res = bus.i_div_ctrl_word ? {{(XLEN-32){spec_val[31]}}, spec_val[31:0]} : spec_val;
    end

    // Sign correction of the core result for the operation held in flight.
    always_comb begin
        core_val   = op_r[1] ? bus.i_div_ctrl_core_remainder : bus.i_div_ctrl_core_quotient;
        neg_res    = op_r[1] ? neg_a_r : (neg_a_r ^ neg_b_r);
        signed_val = neg_res ? -core_val : core_val;
        post_res   = word_r ? {{(XLEN-32){signed_val[31]}}, signed_val[31:0]} : signed_val;
    end

    always_ff @(posedge i_div_ctrl_clk) begin
        if (i_div_ctrl_rst) begin
            state      <= IDLE;
            op_r       <= '0;
            word_r     <= 1'b0;
            neg_a_r    <= 1'b0;
            neg_b_r    <= 1'b0;
            valid_r    <= 1'b0;
            core_en_r  <= 1'b0;
            result_r   <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
        end else begin
            valid_r   <= 1'b0;
            core_en_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (special) begin
                            valid_r  <= 1'b1;
                            result_r <= spec_res;
                        end else begin
                            dividend_r <= mag_a;
                            divisor_r  <= mag_b;
                            neg_a_r    <= neg_a;
                            neg_b_r    <= neg_b;
                            op_r       <= bus.i_div_ctrl_op;
                            word_r     <= bus.i_div_ctrl_word;
                            core_en_r  <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // The start pulse already went out this cycle, so a flush must drain the core.
                    state <= bus.i_div_ctrl_flush ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (bus.i_div_ctrl_core_done) begin
                        if (!bus.i_div_ctrl_flush) begin
                            result_r <= post_res;
                            valid_r  <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (bus.i_div_ctrl_flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.i_div_ctrl_core_done) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
